ifu_fetch: RTL and testbench
============================

# ifu_fetch

Parametrised instruction fetch unit that replaces the free-running PC incrementer with a handshaked front end. It issues one outstanding request to instruction memory, tolerating variable memory latency. It buffers returned instructions in a small FIFO and presents them to the IDU through valid/ready. It accepts redirects from the backend, discarding stale in-flight responses.

## Interface
- ADDR_WIDTH, 32, fetch address width
- INST_WIDTH, 32, instruction width
- RESET_PC, 32'h8000_0000, first fetch address after reset
- FBUF_DEPTH, 2, fetch buffer entries; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- imem_req_valid_o  out  1  request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  ADDR_WIDTH  request address
- imem_resp_valid_i  in  1  response valid; always accepted
- imem_resp_data_i  in  INST_WIDTH  response instruction
- redirect_valid_i  in  1  backend redirect strobe
- redirect_pc_i  in  ADDR_WIDTH  redirect target
- idu_valid_o  out  1  instruction available
- idu_ready_i  in  1  IDU accepts
- idu_pc_o  out  ADDR_WIDTH  PC of head entry
- idu_instr_o  out  INST_WIDTH  head instruction
- idu_exc_o  out  1  head entry is an instruction-address-misaligned fault

## Operation
- Registers: fetch_pc, req_pc (address of the in-flight request), state, stale flag, FIFO of {pc, instr, exc}.
- States:
  - REQ: imem_req_valid_o = (count < FBUF_DEPTH). On handshake, req_pc <= fetch_pc, fetch_pc <= fetch_pc+4, go to WAIT.
  - WAIT: imem_req_valid_o = 0. On resp_valid: if !stale, push {req_pc, data, 0}; else drop and clear stale. Go to REQ.
  - HALT: only when the macro is set. No requests. A response arriving here is dropped and clears stale.
- Request stability: once valid is asserted, valid and addr are held until ready, even across a redirect.
- Credit: only one request is outstanding, and it is issued only when count < FBUF_DEPTH, so a push never overflows.
- FIFO: head/tail pointers wrap modulo FBUF_DEPTH. Push and pop in the same cycle leave count unchanged. PC increments wrap modulo 2^ADDR_WIDTH.
- IDU side: idu_valid_o = (count != 0). The head is popped on valid&&ready.
- Redirect (highest priority):
  - The FIFO is flushed (count <= 0) and fetch_pc <= redirect_pc_i.
  - stale <= 1 if a request is in flight after this edge: state WAIT without resp this cycle, REQ with valid&&!ready, or a REQ handshake this same cycle.
  - Redirect together with resp in WAIT: the response is dropped and stale is not set.
  - Redirect together with an IDU pop: the pop completes and the flush still applies.
  - The next request to redirect_pc_i waits until any pending stale request is accepted and its response returns.

## Timing
- Reset value of every output while rst = 1: req_valid 0, req_addr RESET_PC, idu_valid 0, idu_pc 0, idu_instr 0, idu_exc 0. state=REQ, stale=0, count=0.
- First cycle with rst = 0: req_valid = 1, req_addr = RESET_PC.
- The earliest response is the cycle after request acceptance. A response in the acceptance cycle is ignored.
- idu_valid_o rises the cycle after the response edge.
- Peak throughput is 1 instruction per 2 cycles.
- All outputs come from registers or from state/count only. There is no combinational path from idu_ready_i or imem_resp_valid_i to any output.

## Configuration
- IFU_MISALIGN_CHECK_EN defined: a redirect with redirect_pc_i[1:0] != 0 does the following.
  - Flushes the FIFO.
  - Pushes one entry {redirect_pc_i, 0, exc=1}.
  - Enters HALT.
  - HALT exits only on the next redirect; an aligned target returns to REQ.
  - The stale response is still dropped.
- Undefined: fetch_pc takes redirect_pc_i with bits [1:0] forced to 0. idu_exc_o is tied 0 and HALT is unreachable.

## Test plan
- Reset then memory with ready = 1 and 1-cycle response, idu_ready = 1 → requests to 0x80000000, 0x80000004, 0x80000008; idu_pc follows, one instruction every 2 cycles.
- idu_ready = 0, FBUF_DEPTH = 2 → exactly 2 entries buffered, then req_valid stays 0. Raise ready → 0x80000000 is delivered first and fetching resumes.
- req_ready low for 5 cycles → addr stable at 0x80000000 and valid held. A redirect to 0x80001000 in cycle 3 → 0x80000000's response is dropped and the first entry delivered has pc 0x80001000.
- Redirect to 0x80002000 in WAIT with response latency 4 → the old response is dropped, the FIFO is emptied, and the next request is to 0x80002000.
- Redirect in the same cycle as resp_valid → no push and no stale. The next request goes to the target with no extra dropped response.
- With IFU_MISALIGN_CHECK_EN, redirect to 0x80000102 → single entry with pc 0x80000102, exc = 1, no further requests. Redirect to 0x80000200 → fetching resumes there. Without the macro, the same redirect fetches from 0x80000100 and exc stays 0.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if
//   Bundles the instruction-memory request/response channel, the backend
//   redirect strobe and the IDU valid/ready channel of the fetch unit.
//
//   Parameters: ADDR_WIDTH (fetch address width), INST_WIDTH (instruction width)
//
//   Signals:
//     imem_req_valid / imem_req_ready / imem_req_addr : fetch request handshake
//     imem_resp_valid / imem_resp_data                : instruction return (always accepted)
//     redirect_valid / redirect_pc                    : backend redirect
//     idu_valid / idu_ready / idu_pc / idu_instr / idu_exc : instruction delivery
//
//   Modports:
//     master : the fetch unit side
//     slave  : the memory / backend / IDU side
interface ifu_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_resp_valid;
    logic [INST_WIDTH-1:0] imem_resp_data;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  idu_valid;
    logic                  idu_ready;
    logic [ADDR_WIDTH-1:0] idu_pc;
    logic [INST_WIDTH-1:0] idu_instr;
    logic                  idu_exc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc,
        output idu_valid, idu_pc, idu_instr, idu_exc,
        input  idu_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc,
        input  idu_valid, idu_pc, idu_instr, idu_exc,
        output idu_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch
//   Handshaked instruction fetch front end. Keeps a single request in flight
//   to instruction memory, buffers returned instructions in a FBUF_DEPTH-entry
//   FIFO and hands them to the IDU over valid/ready. Backend redirects flush
//   the FIFO and mark any in-flight request stale so its response is dropped.
//
//   Parameters: ADDR_WIDTH, INST_WIDTH, RESET_PC (first fetch address),
//               FBUF_DEPTH (power of two, >= 2)
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset
//     bus  : ifu_fetch_if.master (imem request/response, redirect, IDU channel)
//
//   Build option: define IFU_MISALIGN_CHECK_EN to turn a redirect to a
//   non-word-aligned target into a single faulting FIFO entry (idu_exc = 1)
//   followed by a halt until the next redirect. Without it the target is
//   word-aligned and idu_exc is tied low.
module ifu_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
    parameter int                    FBUF_DEPTH = 2
) (
    input logic       clk,
    input logic       rst,
    ifu_fetch_if.master bus
);
    localparam int PTR_W = $clog2(FBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(3'd4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(2'd3);

    logic [1:0]            state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0] fetch_pc_r, fetch_pc_nxt_s;
    logic [ADDR_WIDTH-1:0] req_addr_r, req_pc_r;
    logic                  stale_r, stale_nxt_s, inflight_s;
    logic [CNT_W-1:0]      count_r, count_nxt_s;
    logic [PTR_W-1:0]      head_r, head_nxt_s, tail_r, tail_nxt_s;

    logic [ADDR_WIDTH-1:0] pc_mem_r    [FBUF_DEPTH];
    logic [INST_WIDTH-1:0] instr_mem_r [FBUF_DEPTH];

    logic                  req_valid_s, req_fire_s, resp_s, push_s, pop_s;
    logic                  misalign_s, fault_s, wr_en_s;
    logic [PTR_W-1:0]      wr_idx_s;
    logic [ADDR_WIDTH-1:0] wr_pc_s;
    logic [INST_WIDTH-1:0] wr_instr_s;

`ifdef IFU_MISALIGN_CHECK_EN
    logic exc_mem_r [FBUF_DEPTH];
    assign misalign_s = (bus.redirect_pc[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // The !rst term keeps the bus quiet during reset while still letting the
    // very first cycle out of reset present RESET_PC.
    assign req_valid_s = !rst && (state_r == ST_REQ) && (count_r < CNT_W'(FBUF_DEPTH));
    assign req_fire_s  = req_valid_s && bus.imem_req_ready;
    assign resp_s      = bus.imem_resp_valid;
    assign push_s      = (state_r == ST_WAIT) && resp_s && !stale_r && !bus.redirect_valid;
    assign pop_s       = (count_r != '0) && bus.idu_ready;
    assign fault_s     = bus.redirect_valid && misalign_s;
    assign wr_en_s     = push_s || fault_s;

    // Control next state: fetch sequencing, then redirect override.
    always_comb begin
        state_nxt_s    = state_r;
        fetch_pc_nxt_s = fetch_pc_r;
        stale_nxt_s    = stale_r;
        inflight_s     = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (req_fire_s) begin
                    state_nxt_s = ST_WAIT;
                    // A stale request carries the old address; fetch_pc already
                    // holds the redirect target and must not advance past it.
                    if (stale_r) begin
                        fetch_pc_nxt_s = fetch_pc_r;
                    end else begin
                        fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
                    end
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (resp_s) begin
                    state_nxt_s = ST_REQ;
                    stale_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_HALT: begin
                if (resp_s) begin
                    stale_nxt_s = 1'b0;
                end else begin
                    stale_nxt_s = stale_r;
                end
            end
            default: begin
                state_nxt_s = ST_REQ;
                stale_nxt_s = 1'b0;
            end
        endcase

        if (bus.redirect_valid) begin
            // A held-but-unaccepted request is withdrawn when halting, so it
            // only counts as in flight on the aligned path.
            inflight_s = req_fire_s
                       || (req_valid_s && !bus.imem_req_ready && !misalign_s)
                       || ((state_r == ST_WAIT) && !resp_s)
                       || ((state_r == ST_HALT) && stale_r && !resp_s);
            stale_nxt_s    = inflight_s;
            fetch_pc_nxt_s = bus.redirect_pc & ALIGN_MASK;
            if (misalign_s) begin
                state_nxt_s = ST_HALT;
            end else if (state_r == ST_HALT) begin
                // Leaving HALT with a stale response still due: wait it out first.
                state_nxt_s = inflight_s ? ST_WAIT : ST_REQ;
            end else begin
                state_nxt_s = (req_fire_s || ((state_r == ST_WAIT) && !resp_s)) ? ST_WAIT : ST_REQ;
            end
        end else begin
            inflight_s = 1'b0;
        end
    end

    // FIFO pointer/count next state; a redirect flushes, optionally leaving the fault entry.
    always_comb begin
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        wr_idx_s    = tail_r;
        wr_pc_s     = req_pc_r;
        wr_instr_s  = bus.imem_resp_data;
        if (bus.redirect_valid) begin
            head_nxt_s  = '0;
            tail_nxt_s  = misalign_s ? PTR_W'(1'b1) : '0;
            count_nxt_s = misalign_s ? CNT_W'(1'b1) : '0;
        end else begin
            head_nxt_s  = head_r + PTR_W'(pop_s);
            tail_nxt_s  = tail_r + PTR_W'(push_s);
            count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
        if (fault_s) begin
            wr_idx_s   = '0;
            wr_pc_s    = bus.redirect_pc;
            wr_instr_s = '0;
        end else begin
            wr_idx_s   = tail_r;
            wr_pc_s    = req_pc_r;
            wr_instr_s = bus.imem_resp_data;
        end
    end

    // Control and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_REQ;
            fetch_pc_r <= RESET_PC;
            req_addr_r <= RESET_PC;
            req_pc_r   <= RESET_PC;
            stale_r    <= 1'b0;
            count_r    <= '0;
            head_r     <= '0;
            tail_r     <= '0;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            stale_r    <= stale_nxt_s;
            count_r    <= count_nxt_s;
            head_r     <= head_nxt_s;
            tail_r     <= tail_nxt_s;
            req_pc_r   <= req_fire_s ? req_addr_r : req_pc_r;
            // An offered request keeps its address until accepted, even across a redirect.
            req_addr_r <= (req_valid_s && !bus.imem_req_ready) ? req_addr_r : fetch_pc_nxt_s;
        end
    end

    // FIFO payload storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FBUF_DEPTH; i++) begin
                pc_mem_r[i]    <= '0;
                instr_mem_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            pc_mem_r[wr_idx_s]    <= wr_pc_s;
            instr_mem_r[wr_idx_s] <= wr_instr_s;
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    // Fault flag storage alongside the payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FBUF_DEPTH; i++) begin
                exc_mem_r[i] <= 1'b0;
            end
        end else if (wr_en_s) begin
            exc_mem_r[wr_idx_s] <= fault_s;
        end
    end
    assign bus.idu_exc = exc_mem_r[head_r];
`else
    assign bus.idu_exc = 1'b0;
`endif

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = req_addr_r;
    assign bus.idu_valid      = (count_r != '0);
    assign bus.idu_pc         = pc_mem_r[head_r];
    assign bus.idu_instr      = instr_mem_r[head_r];
endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
    localparam int          AW    = 32;
    localparam int          IW    = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_fetch_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();
    ifu_fetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC(RPC), .FBUF_DEPTH(DEPTH))
        dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    // stimulus knobs
    int ready_pct, lat_lo, lat_hi, idu_pct, junk_pct, redir_pct;
    bit redir_req, redir_on_resp;
    logic [31:0] redir_pc_k;

    // memory model: a single pending request and its remaining latency
    bit pend;
    logic [31:0] pend_addr;
    int pend_cnt;

    // delivery model: program-order stream restarting at every redirect
    logic [31:0] exp_pc;
    bit exp_exc, dead, halted;
    bit prev_hold;
    logic [31:0] prev_addr;
    int cyc;
    logic [31:0] fire_q[$], pop_q[$];
    int pop_cyc_q[$];

    // sampled outputs
    logic s_rv, s_iv, s_exc;
    logic [31:0] s_ra, s_ipc, s_ins;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit misaligned(input logic [31:0] t);
`ifdef IFU_MISALIGN_CHECK_EN
        return t[1:0] != 2'b00;
`else
        return t[1:0] != t[1:0];
`endif
    endfunction

    task automatic set_knobs(input int r, input int lo, input int hi, input int i, input int j, input int rd);
        ready_pct = r; lat_lo = lo; lat_hi = hi; idu_pct = i; junk_pct = j; redir_pct = rd;
    endtask

    // One clock cycle: sample at negedge+1, drive inputs, update models, wait next negedge.
    task automatic tick();
        bit pend0, resp, rdy, fire, irdy, pop, redir, forced;
        logic [31:0] rdata, rtgt;
        #1;
        s_rv = bus.imem_req_valid; s_ra = bus.imem_req_addr;
        s_iv = bus.idu_valid; s_ipc = bus.idu_pc; s_ins = bus.idu_instr; s_exc = bus.idu_exc;
        pend0 = pend; resp = 1'b0; rdata = 32'h0;
        if (pend) begin
            if (pend_cnt <= 1) begin
                resp = 1'b1; rdata = imem_word(pend_addr); pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        rdy  = (int'($urandom_range(99, 0)) < ready_pct);
        fire = s_rv && rdy;
        if (prev_hold) begin
            checks++;
            if (s_rv !== 1'b1 || s_ra !== prev_addr) begin
                failures++;
                $display("FAIL req_hold: valid=%0b addr=%h, required valid=1 addr=%h", s_rv, s_ra, prev_addr);
            end
        end
        if (fire) begin
            checks++;
            if (pend0 || halted) begin
                failures++;
                $display("FAIL req_issue: request %h with pending=%0b halted=%0b, required both 0", s_ra, pend0, halted);
            end
            pend = 1'b1; pend_addr = s_ra; pend_cnt = int'($urandom_range(lat_hi, lat_lo));
            fire_q.push_back(s_ra);
            // garbage in the acceptance cycle must be ignored
            if (!resp && int'($urandom_range(99, 0)) < junk_pct) begin
                resp = 1'b1; rdata = 32'hDEAD_BEEF;
            end
        end
        irdy = (int'($urandom_range(99, 0)) < idu_pct);
        pop  = s_iv && irdy;
        if (pop) begin
            checks++;
            if (exp_exc) begin
                if (s_ipc !== exp_pc || s_exc !== 1'b1 || s_ins !== 32'h0) begin
                    failures++;
                    $display("FAIL idu_fault: pc=%h exc=%0b instr=%h, required pc=%h exc=1 instr=0", s_ipc, s_exc, s_ins, exp_pc);
                end
                exp_exc = 1'b0; dead = 1'b1;
            end else if (dead) begin
                failures++;
                $display("FAIL idu_halted: popped pc=%h, required no entry while halted", s_ipc);
            end else begin
                if (s_ipc !== exp_pc || s_ins !== imem_word(exp_pc) || s_exc !== 1'b0) begin
                    failures++;
                    $display("FAIL idu_stream: pc=%h instr=%h exc=%0b, required pc=%h instr=%h exc=0",
                             s_ipc, s_ins, s_exc, exp_pc, imem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            pop_q.push_back(s_ipc); pop_cyc_q.push_back(cyc);
        end
        forced = redir_req || (redir_on_resp && resp && pend0);
        redir  = forced || (int'($urandom_range(999, 0)) < redir_pct * 10);
        rtgt   = forced ? redir_pc_k : (RPC | (32'($urandom_range(4095, 0)) << 2));
        if (forced) begin redir_req = 1'b0; redir_on_resp = 1'b0; end
        bus.imem_req_ready = rdy; bus.imem_resp_valid = resp; bus.imem_resp_data = rdata;
        bus.idu_ready = irdy; bus.redirect_valid = redir; bus.redirect_pc = rtgt;
        if (redir) begin
            if (misaligned(rtgt)) begin
                exp_pc = rtgt; exp_exc = 1'b1; halted = 1'b1;
            end else begin
                exp_pc = rtgt & ~32'h3; exp_exc = 1'b0; halted = 1'b0;
            end
            dead = 1'b0;
        end
        prev_hold = s_rv && !rdy && !(redir && misaligned(rtgt));
        prev_addr = s_ra;
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive_idle();
        bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = 32'h0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.idu_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pend = 1'b0; exp_pc = RPC; exp_exc = 1'b0; dead = 1'b0; halted = 1'b0;
        prev_hold = 1'b0; cyc = 0; redir_req = 1'b0; redir_on_resp = 1'b0;
        fire_q.delete(); pop_q.delete(); pop_cyc_q.delete();
    endtask

    task automatic test_reset();
        logic [31:0] obs[8], req[8];
        rst = 1'b1; drive_idle();
        repeat (2) @(negedge clk);
        #1;
        obs[0] = 32'(bus.imem_req_valid); req[0] = 32'h0;
        obs[1] = bus.imem_req_addr;       req[1] = RPC;
        obs[2] = 32'(bus.idu_valid);      req[2] = 32'h0;
        obs[3] = bus.idu_pc;              req[3] = 32'h0;
        obs[4] = bus.idu_instr;           req[4] = 32'h0;
        obs[5] = 32'(bus.idu_exc);        req[5] = 32'h0;
        rst = 1'b0;
        #1;
        obs[6] = 32'(bus.imem_req_valid); req[6] = 32'h1;
        obs[7] = bus.imem_req_addr;       req[7] = RPC;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (obs[i] !== req[i]) begin
                failures++;
                $display("FAIL reset_%0d: got %h, required %h", i, obs[i], req[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stream();
        do_reset(); set_knobs(100, 1, 1, 100, 0, 0);
        repeat (12) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fire_q.size() <= i || fire_q[i] !== RPC + 32'(4 * i)) begin
                failures++;
                $display("FAIL stream_addr_%0d: got %h, required %h", i, (fire_q.size() > i) ? fire_q[i] : 32'hx, RPC + 32'(4 * i));
            end
        end
        checks++;
        if (pop_q.size() < 5) begin
            failures++;
            $display("FAIL stream_count: got %0d pops, required at least 5", pop_q.size());
        end
        for (int i = 1; i < pop_cyc_q.size(); i++) begin
            checks++;
            if (pop_cyc_q[i] - pop_cyc_q[i-1] != 2) begin
                failures++;
                $display("FAIL stream_rate: pop gap %0d, required 2", pop_cyc_q[i] - pop_cyc_q[i-1]);
            end
        end
    endtask

    task automatic test_fill();
        int n;
        do_reset(); set_knobs(100, 1, 1, 0, 0, 0);
        repeat (10) tick();
        checks++;
        if (fire_q.size() != DEPTH || s_iv !== 1'b1 || s_rv !== 1'b0) begin
            failures++;
            $display("FAIL fill_stop: fires=%0d idu_valid=%0b req_valid=%0b, required fires=%0d 1 0", fire_q.size(), s_iv, s_rv, DEPTH);
        end
        n = fire_q.size();
        idu_pct = 100;
        repeat (8) tick();
        checks++;
        if (pop_q.size() == 0 || pop_q[0] !== RPC || fire_q.size() <= n) begin
            failures++;
            $display("FAIL fill_resume: first pop=%h fires=%0d, required %h and more than %0d", (pop_q.size() > 0) ? pop_q[0] : 32'hx, fire_q.size(), RPC, n);
        end
    endtask

    task automatic test_hold_redirect();
        do_reset(); set_knobs(0, 1, 1, 100, 0, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin redir_req = 1'b1; redir_pc_k = 32'h8000_1000; end
            tick();
        end
        checks++;
        if (s_rv !== 1'b1 || s_ra !== RPC) begin
            failures++;
            $display("FAIL hold_stable: valid=%0b addr=%h, required 1 %h", s_rv, s_ra, RPC);
        end
        ready_pct = 100;
        repeat (12) tick();
        checks++;
        if (fire_q.size() < 2 || fire_q[0] !== RPC || fire_q[1] !== 32'h8000_1000 || pop_q.size() == 0 || pop_q[0] !== 32'h8000_1000) begin
            failures++;
            $display("FAIL hold_redirect: fires=%0d pops=%0d, required held %h then %h delivered first", fire_q.size(), pop_q.size(), RPC, 32'h8000_1000);
        end
    endtask

    task automatic test_wait_redirect();
        int n = 0;
        do_reset(); set_knobs(100, 4, 4, 0, 0, 0);
        while (fire_q.size() < 2 && n < 20) begin tick(); n++; end
        checks++;
        if (fire_q.size() < 2) begin
            failures++;
            $display("FAIL wait_setup: %0d requests within 20 cycles, required 2", fire_q.size());
        end
        tick();
        redir_req = 1'b1; redir_pc_k = 32'h8000_2000;
        tick();
        tick();
        checks++;
        if (s_iv !== 1'b0) begin
            failures++;
            $display("FAIL wait_flush: idu_valid=%0b, required 0", s_iv);
        end
        idu_pct = 100;
        repeat (20) tick();
        checks++;
        if (fire_q.size() < 3 || fire_q[2] !== 32'h8000_2000 || pop_q.size() == 0 || pop_q[0] !== 32'h8000_2000) begin
            failures++;
            $display("FAIL wait_redirect: next req=%h first pop=%h, required %h", (fire_q.size() > 2) ? fire_q[2] : 32'hx,
                     (pop_q.size() > 0) ? pop_q[0] : 32'hx, 32'h8000_2000);
        end
    endtask

    task automatic test_redirect_with_resp();
        do_reset(); set_knobs(100, 2, 2, 100, 0, 0);
        redir_on_resp = 1'b1; redir_pc_k = 32'h8000_3000;
        repeat (3) tick();
        tick();
        checks++;
        if (redir_on_resp || s_iv !== 1'b0) begin
            failures++;
            $display("FAIL resp_redirect_push: pending=%0b idu_valid=%0b, required 0 0", redir_on_resp, s_iv);
        end
        repeat (10) tick();
        checks++;
        if (fire_q.size() < 2 || fire_q[1] !== 32'h8000_3000 || pop_q.size() == 0 || pop_q[0] !== 32'h8000_3000) begin
            failures++;
            $display("FAIL resp_redirect_target: req=%h pop=%h, required %h", (fire_q.size() > 1) ? fire_q[1] : 32'hx,
                     (pop_q.size() > 0) ? pop_q[0] : 32'hx, 32'h8000_3000);
        end
    endtask

    task automatic test_misalign();
        int n;
        do_reset(); set_knobs(100, 1, 1, 0, 0, 0);
        repeat (3) tick();
        redir_req = 1'b1; redir_pc_k = 32'h8000_0102;
        tick();
        idu_pct = 100;
        repeat (10) tick();
        checks++;
`ifdef IFU_MISALIGN_CHECK_EN
        if (pop_q.size() != 1 || pop_q[0] !== 32'h8000_0102 || fire_q.size() != 2) begin
            failures++;
            $display("FAIL misalign_halt: pops=%0d fires=%0d, required 1 entry at %h and 2 fires", pop_q.size(), fire_q.size(), 32'h8000_0102);
        end
`else
        if (pop_q.size() == 0 || pop_q[0] !== 32'h8000_0100 || fire_q.size() < 3 || fire_q[2] !== 32'h8000_0100) begin
            failures++;
            $display("FAIL misalign_align: first pop=%h, required %h", (pop_q.size() > 0) ? pop_q[0] : 32'hx, 32'h8000_0100);
        end
`endif
        n = pop_q.size();
        redir_req = 1'b1; redir_pc_k = 32'h8000_0200;
        tick();
        n = pop_q.size();
        repeat (10) tick();
        checks++;
        if (pop_q.size() <= n || pop_q[n] !== 32'h8000_0200) begin
            failures++;
            $display("FAIL misalign_resume: pop=%h, required %h", (pop_q.size() > n) ? pop_q[n] : 32'hx, 32'h8000_0200);
        end
    endtask

    task automatic test_random();
        do_reset(); set_knobs(70, 1, 4, 60, 30, 3);
        repeat (3000) tick();
        checks++;
        if (pop_q.size() < 100) begin
            failures++;
            $display("FAIL random_progress: %0d instructions, required at least 100", pop_q.size());
        end
    endtask

    initial begin
        drive_idle();
        set_knobs(0, 1, 1, 0, 0, 0);
        redir_req = 1'b0; redir_on_resp = 1'b0; redir_pc_k = 32'h0;
        test_reset();
        test_stream();
        test_fill();
        test_hold_redirect();
        test_wait_redirect();
        test_redirect_with_resp();
        test_misalign();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
